// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-stage register fields in, stall/flush/forward controls out.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_rf_wb;
  logic [1:0] ex_wb_src;
  logic       ex_branch_taken;
  logic       ex_jump;
  logic [4:0] mem_rd;
  logic       mem_rf_wb;
  logic       mem_req;
  logic       mem_ready;
  logic [4:0] wb_rd;
  logic       wb_rf_wb;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       flush_id;
  logic       bubble_ex;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       busy;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_rf_wb,
           ex_wb_src, ex_branch_taken, ex_jump, mem_rd, mem_rf_wb, mem_req, mem_ready,
           wb_rd, wb_rf_wb,
    input  stall_if, stall_id, stall_ex, flush_id, bubble_ex, fwd_a, fwd_b, busy
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_rf_wb,
           ex_wb_src, ex_branch_taken, ex_jump, mem_rd, mem_rf_wb, mem_req, mem_ready,
           wb_rd, wb_rf_wb,
    output stall_if, stall_id, stall_ex, flush_id, bubble_ex, fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forward control with RUN/MEM_WAIT/REDIRECT FSM.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
  state_t state, state_nxt;
  logic mem_stall, redirect, load_use, stall, flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    mem_stall = hz.mem_req & ~hz.mem_ready;
    redirect  = (hz.ex_branch_taken | hz.ex_jump) & ~mem_stall;
    load_use  = hz.ex_rf_wb & (hz.ex_wb_src == 2'b01) & (hz.ex_rd != 5'd0) &
                ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) | (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
    state_nxt = mem_stall ? MEM_WAIT : redirect ? REDIRECT : RUN;
    // REDIRECT adds the second flush cycle that covers the two-deep fetch pipe
    stall = rst_n & (mem_stall | (load_use & ~redirect));
    flush = rst_n & ~mem_stall & (redirect | (state == REDIRECT));
    hz.stall_if  = stall;
    hz.stall_id  = stall;
    hz.stall_ex  = rst_n & mem_stall;
    hz.flush_id  = flush;
    hz.bubble_ex = rst_n & ~mem_stall & (redirect | load_use);
    hz.busy      = state != RUN;
    hz.fwd_a = (hz.mem_rf_wb && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1) ? 2'b01 :
               (hz.wb_rf_wb && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs1) ? 2'b10 : 2'b00;
    hz.fwd_b = (hz.mem_rf_wb && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2) ? 2'b01 :
               (hz.wb_rf_wb && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs2) ? 2'b10 : 2'b00;
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
`endif
endmodule
